clock_pattern_monitor: RTL

- Downstream consumer of the clock test pattern block's 32-bit data_out bus. Each byte of that bus is launched from a different derived or combined clock.
- Re-times the bus into the clk_a domain and accepts a new value only after it has been bit-stable for STABLE_CYCLES cycles.
- Compacts accepted values into a 32-bit MISR signature, counts updates and records which byte lanes changed, for a run of a programmed length.
- Gives the bench and silicon debug one deterministic signature per pattern run.

---
 rtl/clock_pattern_monitor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/clock_pattern_monitor.sv
// Re-times an asynchronous multi-clock bus into clk_a, accepts values once bit-stable,
// and compacts accepted values into a MISR signature over a programmed-length run.
module clock_pattern_monitor #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned TO_W          = 12,
   parameter logic [31:0] MISR_SEED     = 32'hFFFF_FFFF,
   parameter logic [31:0] MISR_POLY     = 32'h04C1_1DB7
) (
   input  logic                  clk_a,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [CNT_W-1:0]      sample_count,
   input  logic [DATA_W-1:0]     mon_data,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [31:0]           signature,
   output logic [CNT_W-1:0]      updates,
   output logic [DATA_W/8-1:0]   lane_toggle
);

   localparam int unsigned LANES = DATA_W / 8;
   localparam int unsigned SC_W  = $clog2(STABLE_CYCLES);
   localparam logic [SC_W-1:0] SC_MAX    = SC_W'(STABLE_CYCLES - 1);
   localparam logic [TO_W-1:0] IDLE_LAST = {{(TO_W-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state, state_d;

   logic [DATA_W-1:0] s1, s2, h, last_acc;
   logic [SC_W-1:0]   stab_cnt;
   logic [TO_W-1:0]   idle_cnt;
   logic [CNT_W-1:0]  cnt_lat;

   logic              event_c;
   logic              clr_c;
   logic              acc_c;
   logic              to_c;
   logic [CNT_W-1:0]  upd_inc_c;
   logic [31:0]       misr_next_c;
   logic [LANES-1:0]  lane_chg_c;

   // Synchronizer, hold register and stability counter run in every state
   always_ff @(posedge clk_a or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= '0;
         s2       <= '0;
         h        <= '0;
         stab_cnt <= '0;
         last_acc <= '0;
      end else begin
         s1 <= mon_data;
         s2 <= s1;
         h  <= s2;
         if (s2 == h) begin
            if (stab_cnt != SC_MAX) stab_cnt <= stab_cnt + SC_W'(1);
         end else begin
            stab_cnt <= '0;
         end
         if (event_c) last_acc <= s2;
      end
   end

   // One event per distinct value that has stayed stable long enough
   assign event_c = (s2 == h) && (stab_cnt == SC_MAX) && (s2 != last_acc);

   assign upd_inc_c   = (updates == '1) ? updates : updates + CNT_W'(1);
   assign misr_next_c = {signature[30:0], 1'b0} ^ (signature[31] ? MISR_POLY : 32'h0) ^ 32'(s2);

   always_comb begin
      for (int i = 0; i < int'(LANES); i++) begin
         lane_chg_c[i] = (s2[8*i +: 8] != last_acc[8*i +: 8]);
      end
   end

   always_ff @(posedge clk_a or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      clr_c   = 1'b0;
      acc_c   = 1'b0;
      to_c    = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               clr_c   = 1'b1;
               state_d = (sample_count == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (event_c) begin
               acc_c = 1'b1;
               if (upd_inc_c == cnt_lat) state_d = ST_DONE;
            end else if (idle_cnt == IDLE_LAST) begin
               to_c    = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Run datapath: clears on start, compaction on event, idle timer otherwise
   always_ff @(posedge clk_a or negedge rst_n) begin
      if (!rst_n) begin
         signature   <= MISR_SEED;
         updates     <= '0;
         lane_toggle <= '0;
         timeout     <= 1'b0;
         idle_cnt    <= '0;
         cnt_lat     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         busy <= (state_d == ST_RUN);
         done <= (state_d == ST_DONE);
         if (clr_c) begin
            signature   <= MISR_SEED;
            updates     <= '0;
            lane_toggle <= '0;
            timeout     <= 1'b0;
            idle_cnt    <= '0;
            cnt_lat     <= sample_count;
         end else if (acc_c) begin
            signature   <= misr_next_c;
            updates     <= upd_inc_c;
            lane_toggle <= lane_toggle | lane_chg_c;
            idle_cnt    <= '0;
         end else if (state == ST_RUN) begin
            idle_cnt <= idle_cnt + TO_W'(1);
            if (to_c) timeout <= 1'b1;
         end
      end
   end

endmodule
